sha256_mem_responder: RTL and testbench

- Memory-side responder for the SHA-256 message-read interface.
- Accepts word read requests (mem_addr_vld/mem_addr) issued by the hash core and returns mem_data_vld/mem_data after a fixed latency.
- Reads come from an internal message buffer, which a host loads through a simple write port gated by a load state machine.
- Sits between the host/DMA and the sha256 top; replaces external memory in standalone builds and benches.

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_mem_ram.sv | 29 ++
 rtl/sha256_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_sha256_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 block and its memory-side responder.
// The byte-reversal helper is used when SHA256_MEM_BYTESWAP_EN is defined.
package sha256_pkg;

  localparam int MEM_WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_EMPTY,
    MEM_LOAD,
    MEM_READY
  } MemState;

  // Reverse byte order so little-endian host words feed the big-endian schedule
  function automatic logic [MEM_WORD_W-1:0] mem_byteswap(input logic [MEM_WORD_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/sha256_mem_ram.sv
// Message buffer storage: one write port, one synchronous read port, no reset.
// A read and a write to the same word in one cycle return the old contents.
module sha256_mem_ram
  import sha256_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
  input  logic [MEM_WORD_W-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
  output logic [MEM_WORD_W-1:0]          rd_data
);

  logic [MEM_WORD_W-1:0] mem [DEPTH_WORDS];

  // Write and registered read share the edge; NBA ordering gives read-before-write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sha256_mem_responder.sv
// Memory-side responder for the SHA-256 message-read interface.
// A host fills the buffer while in LOAD; the hash core then reads words with a
// fixed READ_LATENCY and no backpressure. Bad reads still get a zero response.
// Optional macro SHA256_MEM_BYTESWAP_EN byte-reverses words in the last stage.
module sha256_mem_responder
  import sha256_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_addr_vld,
  input  logic [31:0]                    mem_addr,
  output logic                           mem_data_vld,
  output logic [MEM_WORD_W-1:0]          mem_data,
  input  logic                           load_start,
  input  logic                           load_done,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
  input  logic [MEM_WORD_W-1:0]          wr_data,
  output logic                           ready,
  output logic                           err_oob,
  output logic                           err_state,
  input  logic                           err_clr,
  output logic [31:0]                    rd_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  MemState               state_q;
  MemState               state_d;
  logic                  ram_we;
  logic [31:0]           req_off;
  logic [31:0]           req_idx;
  logic                  req_oob;
  logic                  req_in_ready;
  logic                  req_zero;
  logic                  oob_event;
  logic                  state_event;
  logic [MEM_WORD_W-1:0] ram_rd_data;
  logic                  s0_vld;
  logic                  s0_zero;
  logic [MEM_WORD_W-1:0] s0_word;

  // Final formatting of a returned word; zero words are unchanged either way
  function automatic logic [MEM_WORD_W-1:0] out_word(input logic [MEM_WORD_W-1:0] w);
`ifdef SHA256_MEM_BYTESWAP_EN
    return mem_byteswap(w);
`else
    return w;
`endif
  endfunction

  // Decode the byte address into a word index and classify the request
  always_comb begin
    req_off      = mem_addr - ADDR_BASE;
    req_idx      = req_off >> 2;
    req_oob      = (mem_addr < ADDR_BASE) || (req_idx >= 32'(DEPTH_WORDS));
    req_in_ready = (state_q == MEM_READY);
    req_zero     = req_oob || !req_in_ready;
    ram_we       = wr_en && (state_q == MEM_LOAD);
    oob_event    = mem_addr_vld && req_oob;
    state_event  = (mem_addr_vld && !req_in_ready) || (wr_en && (state_q != MEM_LOAD));
  end

  // Next-state logic: load_start wins from anywhere, load_done only leaves LOAD
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = MEM_LOAD;
    end else if (load_done && (state_q == MEM_LOAD)) begin
      state_d = MEM_READY;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign ready = (state_q == MEM_READY);

  // Sticky error flags (a new event beats a clear) and the accepted-read counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_oob   <= 1'b0;
      err_state <= 1'b0;
      rd_count  <= 32'd0;
    end else begin
      if (oob_event) begin
        err_oob <= 1'b1;
      end else if (err_clr) begin
        err_oob <= 1'b0;
      end
      if (state_event) begin
        err_state <= 1'b1;
      end else if (err_clr) begin
        err_state <= 1'b0;
      end
      if (mem_addr_vld && req_in_ready) begin
        rd_count <= rd_count + 32'd1;
      end
    end
  end

  sha256_mem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (mem_addr_vld),
    .rd_addr(req_idx[AW-1:0]),
    .rd_data(ram_rd_data)
  );

  // First stage runs alongside the RAM read: remember validity and zero-forcing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld  <= 1'b0;
      s0_zero <= 1'b0;
    end else begin
      s0_vld  <= mem_addr_vld;
      s0_zero <= req_zero;
    end
  end

  assign s0_word = s0_zero ? '0 : ram_rd_data;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      logic [MEM_WORD_W-1:0] hold_q;

      // Keep the last returned word so mem_data holds between responses
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hold_q <= '0;
        end else if (s0_vld) begin
          hold_q <= out_word(s0_word);
        end
      end

      assign mem_data_vld = s0_vld;
      assign mem_data     = s0_vld ? out_word(s0_word) : hold_q;
    end else begin : g_latn
      localparam int NS = READ_LATENCY - 1;

      logic [NS-1:0]         in_vld;
      logic [NS-1:0]         vld_q;
      logic [MEM_WORD_W-1:0] in_data [NS];
      logic [MEM_WORD_W-1:0] data_q  [NS];

      // Chain the stage inputs: stage 0 is fed by the RAM stage
      always_comb begin
        in_vld     = '0;
        in_vld[0]  = s0_vld;
        in_data[0] = s0_word;
        for (int i = 1; i < NS; i++) begin
          in_vld[i]  = vld_q[i-1];
          in_data[i] = data_q[i-1];
        end
      end

      // Delay stages; the last one formats the word and holds it when idle
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= '0;
          for (int i = 0; i < NS; i++) begin
            data_q[i] <= '0;
          end
        end else begin
          vld_q <= in_vld;
          for (int i = 0; i < NS; i++) begin
            if (i == NS - 1) begin
              if (in_vld[i]) begin
                data_q[i] <= out_word(in_data[i]);
              end
            end else begin
              data_q[i] <= in_data[i];
            end
          end
        end
      end

      assign mem_data_vld = vld_q[NS-1];
      assign mem_data     = data_q[NS-1];
    end
  endgenerate

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Self-checking bench for sha256_mem_responder with a queue-based reference model.
module tb_sha256_mem_responder;

  localparam int          DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          LAT     = 2;
  localparam int          M_EMPTY = 0;
  localparam int          M_LOAD  = 1;
  localparam int          M_READY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_addr_vld = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic        mem_data_vld;
  logic [31:0] mem_data;
  logic        load_start = 1'b0;
  logic        load_done = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = 10'h0;
  logic [31:0] wr_data = 32'h0;
  logic        ready;
  logic        err_oob;
  logic        err_state;
  logic        err_clr = 1'b0;
  logic [31:0] rd_count;

  always #5 clk = ~clk;

  sha256_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_BASE   (BASE),
    .READ_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr_vld(mem_addr_vld),
    .mem_addr    (mem_addr),
    .mem_data_vld(mem_data_vld),
    .mem_data    (mem_data),
    .load_start  (load_start),
    .load_done   (load_done),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ready       (ready),
    .err_oob     (err_oob),
    .err_state   (err_state),
    .err_clr     (err_clr),
    .rd_count    (rd_count)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic [31:0] m_mem [DEPTH];
  int          m_state;
  logic        m_oob;
  logic        m_err_state;
  logic [31:0] m_count;
  logic [31:0] m_last;
  int          due_q[$];
  logic [31:0] dat_q[$];
  logic        exp_vld;
  logic [31:0] exp_data;

  function automatic logic [31:0] host_view(input logic [31:0] w);
`ifdef SHA256_MEM_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic model_reset();
    m_state     = M_EMPTY;
    m_oob       = 1'b0;
    m_err_state = 1'b0;
    m_count     = 32'd0;
    m_last      = 32'd0;
    due_q.delete();
    dat_q.delete();
    exp_vld  = 1'b0;
    exp_data = 32'd0;
  endtask

  // Drive one cycle of inputs, advance the model, and step past the clock edge
  task automatic step(input logic av, input logic [31:0] a, input logic ls, input logic ld,
                      input logic we, input logic [9:0] wa, input logic [31:0] wd,
                      input logic clr);
    logic [31:0] off;
    logic        oob;
    logic        set_oob;
    logic        set_state;
    logic [31:0] d;
    mem_addr_vld = av;
    mem_addr     = a;
    load_start   = ls;
    load_done    = ld;
    wr_en        = we;
    wr_addr      = wa;
    wr_data      = wd;
    err_clr      = clr;
    set_oob      = 1'b0;
    set_state    = 1'b0;
    if (av) begin
      off = a - BASE;
      oob = (a < BASE) || ((off / 4) >= DEPTH);
      d   = 32'h0;
      if (oob) set_oob = 1'b1;
      if (m_state != M_READY) begin
        set_state = 1'b1;
      end else begin
        m_count = m_count + 32'd1;
        if (!oob) d = host_view(m_mem[off / 4]);
      end
      due_q.push_back(cyc + LAT);
      dat_q.push_back(d);
    end
    if (we) begin
      if (m_state == M_LOAD) m_mem[wa] = wd;
      else set_state = 1'b1;
    end
    m_oob       = set_oob | (m_oob & ~clr);
    m_err_state = set_state | (m_err_state & ~clr);
    if (ls) m_state = M_LOAD;
    else if (ld && m_state == M_LOAD) m_state = M_READY;
    @(posedge clk);
    #1;
    cyc++;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_vld  = 1'b1;
      exp_data = dat_q.pop_front();
      void'(due_q.pop_front());
      m_last   = exp_data;
    end else begin
      exp_vld  = 1'b0;
      exp_data = m_last;
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #2;
    tests_run++; if (mem_data_vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_vld: got %b want 0", mem_data_vld); end
    tests_run++; if (mem_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h want 0", mem_data); end
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
    tests_run++; if (err_oob !== 1'b0 || err_state !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b%b want 00", err_oob, err_state); end
    tests_run++; if (rd_count !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d want 0", rd_count); end
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b1;
  endtask

  task automatic test_load_and_read();
    int k;
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'(i), 32'h1000_0000 + 32'(i), 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0);
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_ready: got %b want 1", ready); end
    for (int i = 0; i < 20; i++) begin
      if (i < 16) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
      else idle();
      k = i - (LAT - 1);
      tests_run++;
      if (mem_data_vld !== (k >= 0 && k < 16)) begin tests_failed++; $display("[TB] FAIL burst_vld[%0d]: got %b want %b", i, mem_data_vld, (k >= 0 && k < 16)); end
      if (k >= 0 && k < 16) begin
        tests_run++;
        if (mem_data !== host_view(32'h1000_0000 + 32'(k))) begin tests_failed++; $display("[TB] FAIL burst_data[%0d]: got %h want %h", k, mem_data, host_view(32'h1000_0000 + 32'(k))); end
      end
    end
    tests_run++; if (rd_count !== 32'd16) begin tests_failed++; $display("[TB] FAIL burst_count: got %0d want 16", rd_count); end
  endtask

  task automatic test_oob();
    step(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    tests_run++; if (err_oob !== 1'b1) begin tests_failed++; $display("[TB] FAIL oob_flag: got %b want 1", err_oob); end
    idle();
    tests_run++; if (mem_data_vld !== 1'b1 || mem_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL oob_resp: got vld=%b data=%h want vld=1 data=0", mem_data_vld, mem_data); end
    tests_run++; if (rd_count !== 32'd17) begin tests_failed++; $display("[TB] FAIL oob_count: got %0d want 17", rd_count); end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1);
    tests_run++; if (err_oob !== 1'b0) begin tests_failed++; $display("[TB] FAIL oob_clear: got %b want 0", err_oob); end
  endtask

  task automatic test_state_err();
    apply_reset();
    step(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    tests_run++; if (err_state !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty_read_flag: got %b want 1", err_state); end
    tests_run++; if (rd_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL empty_read_count: got %0d want 0", rd_count); end
    idle();
    tests_run++; if (mem_data_vld !== 1'b1 || mem_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL empty_read_resp: got vld=%b data=%h want vld=1 data=0", mem_data_vld, mem_data); end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1);
    tests_run++; if (err_state !== 1'b0) begin tests_failed++; $display("[TB] FAIL state_clear: got %b want 0", err_state); end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0);
    tests_run++; if (err_state !== 1'b1) begin tests_failed++; $display("[TB] FAIL ready_write_flag: got %b want 1", err_state); end
    step(1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    idle();
    tests_run++; if (mem_data_vld !== 1'b1 || mem_data !== host_view(32'h1000_0005)) begin tests_failed++; $display("[TB] FAIL ready_write_kept: got vld=%b data=%h want vld=1 data=%h", mem_data_vld, mem_data, host_view(32'h1000_0005)); end
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    mem_addr_vld = 1'b0;
    rst = 1'b0;
    model_reset();
    #2;
    tests_run++; if (mem_data_vld !== 1'b0 || mem_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL midreset_out: got vld=%b data=%h want vld=0 data=0", mem_data_vld, mem_data); end
    tests_run++; if (ready !== 1'b0 || err_oob !== 1'b0 || err_state !== 1'b0 || rd_count !== 32'h0) begin tests_failed++; $display("[TB] FAIL midreset_status: got ready=%b oob=%b st=%b cnt=%0d want all 0", ready, err_oob, err_state, rd_count); end
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      tests_run++; if (mem_data_vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_ghost[%0d]: got %b want 0", i, mem_data_vld); end
    end
  endtask

  task automatic test_load_priority();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0);
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL prio_ready: got %b want 0", ready); end
    tests_run++; if (mem_data_vld !== 1'b1 || mem_data !== host_view(32'h1000_0002)) begin tests_failed++; $display("[TB] FAIL prio_inflight: got vld=%b data=%h want vld=1 data=%h", mem_data_vld, mem_data, host_view(32'h1000_0002)); end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0);
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL prio_done: got %b want 1", ready); end
  endtask

  task automatic test_byteswap();
    logic [31:0] want;
`ifdef SHA256_MEM_BYTESWAP_EN
    want = 32'h3322_1100;
`else
    want = 32'h0011_2233;
`endif
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'd20, 32'h0011_2233, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0050, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    idle();
    tests_run++; if (mem_data_vld !== 1'b1 || mem_data !== want) begin tests_failed++; $display("[TB] FAIL byteswap: got vld=%b data=%h want vld=1 data=%h", mem_data_vld, mem_data, want); end
  endtask

  task automatic test_random();
    logic        av, ls, ld, we, clr;
    logic [31:0] a;
    int          r;
    apply_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'(i), $urandom, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      av = ($urandom_range(0, 99) < 70);
      r  = $urandom_range(0, 99);
      if (r < 6) a = $urandom;
      else if (r < 9) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      ls  = ($urandom_range(0, 99) < 2);
      ld  = ($urandom_range(0, 99) < 8);
      we  = ($urandom_range(0, 99) < 10);
      clr = ($urandom_range(0, 99) < 5);
      step(av, a, ls, ld, we, 10'($urandom_range(0, DEPTH - 1)), $urandom, clr);
      tests_run++; if (mem_data_vld !== exp_vld) begin tests_failed++; $display("[TB] FAIL rand_vld@%0d: got %b want %b", cyc, mem_data_vld, exp_vld); end
      tests_run++; if (mem_data !== exp_data) begin tests_failed++; $display("[TB] FAIL rand_data@%0d: got %h want %h", cyc, mem_data, exp_data); end
      tests_run++; if (ready !== (m_state == M_READY)) begin tests_failed++; $display("[TB] FAIL rand_ready@%0d: got %b want %b", cyc, ready, (m_state == M_READY)); end
      tests_run++; if (err_oob !== m_oob || err_state !== m_err_state) begin tests_failed++; $display("[TB] FAIL rand_err@%0d: got %b%b want %b%b", cyc, err_oob, err_state, m_oob, m_err_state); end
      tests_run++; if (rd_count !== m_count) begin tests_failed++; $display("[TB] FAIL rand_count@%0d: got %0d want %0d", cyc, rd_count, m_count); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_and_read();
    test_oob();
    test_state_err();
    test_reset_midflight();
    test_load_priority();
    test_byteswap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
